// File: rtl/control_fsm.sv
// control_fsm: multi-cycle datapath controller (Moore FSM).
// The opcode is sampled into r_op when leaving DECODE. All outputs decode from
// r_state and r_op only, so there is no combinational path from the opcode input.
// Ports:
//   clock, reset (async, active-high), opcode[5:0] - inputs
//   IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond, RegDst, branch,
//   regA_mux (1b); ALUsrcA, ALUsrcB, PCsource, Load (2b); ALUop (4b) - datapath controls
//   halted, illegal (1b); state[3:0] - status/debug
module control_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       IRwrite,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCwrite,
    output logic       PCwritecond,
    output logic       RegDst,
    output logic       branch,
    output logic       regA_mux,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] PCsource,
    output logic [1:0] Load,
    output logic [3:0] ALUop,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] ST_INIT   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC_R = 4'd3;
    localparam logic [3:0] ST_EXEC_I = 4'd4;
    localparam logic [3:0] ST_ALU_WB = 4'd5;
    localparam logic [3:0] ST_MEM_RD = 4'd6;
    localparam logic [3:0] ST_MEM_WB = 4'd7;
    localparam logic [3:0] ST_MEM_WR = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_JUMP   = 4'd10;
    localparam logic [3:0] ST_HALT   = 4'd11;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_XOR  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001001;
    localparam logic [5:0] OP_ORI  = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b010000;
    localparam logic [5:0] OP_BNE  = 6'b010001;
    localparam logic [5:0] OP_J    = 6'b010010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    logic [3:0] r_state;
    logic [5:0] r_op;
    logic       r_illegal;
    logic [3:0] w_next;
    logic       w_set_illegal;

    // Next-state logic; only DECODE looks at the live opcode input.
    always_comb begin
        w_next        = ST_HALT;
        w_set_illegal = 1'b0;
        case (r_state)
            ST_INIT:   w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_next = ST_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI:              w_next = ST_EXEC_I;
                    OP_LW:                                 w_next = ST_MEM_RD;
                    OP_SW:                                 w_next = ST_MEM_WR;
                    OP_BEQ, OP_BNE:                        w_next = ST_BRANCH;
                    OP_J:                                  w_next = ST_JUMP;
                    OP_HALT:                               w_next = ST_HALT;
                    default: begin
                        w_next        = ST_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I:                     w_next = ST_ALU_WB;
            ST_MEM_RD:                                w_next = ST_MEM_WB;
            ST_ALU_WB, ST_MEM_WB, ST_MEM_WR,
            ST_BRANCH, ST_JUMP:                       w_next = ST_FETCH;
            ST_HALT:                                  w_next = ST_HALT;
            default: begin
                // Unused encodings 12-15 trap to HALT.
                w_next        = ST_HALT;
                w_set_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_op      <= 6'b000000;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op <= opcode;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Moore output decode from r_state and r_op.
    always_comb begin
        IRwrite     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        PCwrite     = 1'b0;
        PCwritecond = 1'b0;
        RegDst      = 1'b0;
        branch      = 1'b0;
        regA_mux    = 1'b0;
        ALUsrcA     = 2'd0;
        ALUsrcB     = 2'd0;
        PCsource    = 2'd0;
        Load        = 2'd0;
        ALUop       = ALU_ADD;
        case (r_state)
            ST_FETCH: begin
                IRwrite = 1'b1;
                ALUsrcB = 2'd1;
                PCwrite = 1'b1;
            end
            ST_DECODE: begin
                ALUsrcB = 2'd2;
            end
            ST_EXEC_R: begin
                ALUsrcA = 2'd1;
                case (r_op)
                    OP_SUB:  ALUop = ALU_SUB;
                    OP_AND:  ALUop = ALU_AND;
                    OP_OR:   ALUop = ALU_OR;
                    OP_XOR:  ALUop = ALU_XOR;
                    default: ALUop = ALU_ADD;
                endcase
            end
            ST_EXEC_I: begin
                ALUsrcA = 2'd1;
                case (r_op)
                    OP_ANDI: begin
                        ALUsrcB = 2'd3;
                        ALUop   = ALU_AND;
                    end
                    OP_ORI: begin
                        ALUsrcB = 2'd3;
                        ALUop   = ALU_OR;
                    end
                    default: ALUsrcB = 2'd2;
                endcase
            end
            ST_ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                regA_mux = 1'b1;
            end
            ST_BRANCH: begin
                ALUsrcA     = 2'd1;
                ALUop       = ALU_SUB;
                PCwritecond = 1'b1;
                PCsource    = 2'd1;
                branch      = (r_op == OP_BEQ);
            end
            ST_JUMP: begin
                PCwrite  = 1'b1;
                PCsource = 2'd2;
            end
            default: ;
        endcase
    end

    assign halted  = (r_state == ST_HALT);
    assign illegal = r_illegal | (r_state > ST_HALT);
    assign state   = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class through the FSM
// and compares state, the full control bundle and halted/illegal at each step.
module tb_control_fsm;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond;
    logic       RegDst, branch, regA_mux, halted, illegal;
    logic [1:0] ALUsrcA, ALUsrcB, PCsource, Load;
    logic [3:0] ALUop, state;

    int total = 0;
    int bad   = 0;

    control_fsm dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .IRwrite     (IRwrite),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .PCwrite     (PCwrite),
        .PCwritecond (PCwritecond),
        .RegDst      (RegDst),
        .branch      (branch),
        .regA_mux    (regA_mux),
        .ALUsrcA     (ALUsrcA),
        .ALUsrcB     (ALUsrcB),
        .PCsource    (PCsource),
        .Load        (Load),
        .ALUop       (ALUop),
        .halted      (halted),
        .illegal     (illegal),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Field order: IRwrite MemWrite MemtoReg RegWrite PCwrite PCwritecond RegDst branch
    // regA_mux ALUsrcA ALUsrcB PCsource Load ALUop
    function automatic logic [20:0] ctl(input logic ir, mw, mr, rw, pw, pc, rd, br, ra,
                                        input logic [1:0] sa, sb, ps, ld,
                                        input logic [3:0] op);
        return {ir, mw, mr, rw, pw, pc, rd, br, ra, sa, sb, ps, ld, op};
    endfunction

    function automatic logic [20:0] obs_ctl();
        return {IRwrite, MemWrite, MemtoReg, RegWrite, PCwrite, PCwritecond, RegDst,
                branch, regA_mux, ALUsrcA, ALUsrcB, PCsource, Load, ALUop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Compare state, control bundle and {halted, illegal} at the current time.
    task automatic look(input string tag, input logic [3:0] st, input logic [20:0] c,
                        input logic [1:0] hi);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'(obs_ctl()), 32'(c));
        chk({tag, ".flags"}, 32'({halted, illegal}), 32'(hi));
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [20:0] c,
                        input logic [1:0] hi);
        @(negedge clock);
        look(tag, st, c, hi);
    endtask

    logic [20:0] c_fetch, c_dec, c_alu_wb, c_mem_wb, c_mem_wr, c_jump;

    initial begin
        c_fetch  = ctl(1, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, 4'd0);
        c_dec    = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, 4'd0);
        c_alu_wb = ctl(0, 0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0);
        c_mem_wb = ctl(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0);
        c_mem_wr = ctl(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0);
        c_jump   = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 4'd0);

        reset  = 1'b1;
        opcode = 6'b000000;
        @(negedge clock);
        look("reset", 4'd0, 21'd0, 2'b00);
        reset = 1'b0;

        // ADD: 0,1,2,3,5,1
        step("add_fetch", 4'd1, c_fetch, 2'b00);
        step("add_dec", 4'd2, c_dec, 2'b00);
        step("add_exec", 4'd3, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0), 2'b00);
        step("add_wb", 4'd5, c_alu_wb, 2'b00);
        step("lw_fetch", 4'd1, c_fetch, 2'b00);

        // LW
        opcode = 6'b100011;
        step("lw_dec", 4'd2, c_dec, 2'b00);
        step("lw_rd", 4'd6, 21'd0, 2'b00);
        step("lw_wb", 4'd7, c_mem_wb, 2'b00);
        step("sw_fetch", 4'd1, c_fetch, 2'b00);

        // SW: MEM_WR for one cycle only
        opcode = 6'b101011;
        step("sw_dec", 4'd2, c_dec, 2'b00);
        step("sw_wr", 4'd8, c_mem_wr, 2'b00);
        step("bne_fetch", 4'd1, c_fetch, 2'b00);

        // BNE then BEQ
        opcode = 6'b010001;
        step("bne_dec", 4'd2, c_dec, 2'b00);
        step("bne_br", 4'd9, ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd1, 2'd0, 2'd1, 2'd0, 4'd1), 2'b00);
        step("beq_fetch", 4'd1, c_fetch, 2'b00);
        opcode = 6'b010000;
        step("beq_dec", 4'd2, c_dec, 2'b00);
        step("beq_br", 4'd9, ctl(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd1, 2'd0, 2'd1, 2'd0, 4'd1), 2'b00);
        step("xor_fetch", 4'd1, c_fetch, 2'b00);

        // XOR; opcode input changes after DECODE, latched value must rule EXEC_R
        opcode = 6'b000100;
        step("xor_dec", 4'd2, c_dec, 2'b00);
        step("xor_exec", 4'd3, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd4), 2'b00);
        opcode = 6'b000001;
        #1;
        look("xor_latched", 4'd3, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd4),
             2'b00);
        step("xor_wb", 4'd5, c_alu_wb, 2'b00);
        step("ori_fetch", 4'd1, c_fetch, 2'b00);

        // ORI
        opcode = 6'b001010;
        step("ori_dec", 4'd2, c_dec, 2'b00);
        step("ori_exec", 4'd4, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd3, 2'd0, 2'd0, 4'd3), 2'b00);
        step("ori_wb", 4'd5, c_alu_wb, 2'b00);
        step("j_fetch", 4'd1, c_fetch, 2'b00);

        // J
        opcode = 6'b010010;
        step("j_dec", 4'd2, c_dec, 2'b00);
        step("j_jump", 4'd10, c_jump, 2'b00);
        step("sw2_fetch", 4'd1, c_fetch, 2'b00);

        // SW interrupted by asynchronous reset between edges
        opcode = 6'b101011;
        step("sw2_dec", 4'd2, c_dec, 2'b00);
        step("sw2_wr", 4'd8, c_mem_wr, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        look("async_rst", 4'd0, 21'd0, 2'b00);
        @(negedge clock);
        look("rst_held", 4'd0, 21'd0, 2'b00);
        reset = 1'b0;
        step("ill_fetch", 4'd1, c_fetch, 2'b00);

        // Illegal opcode -> HALT with sticky illegal
        opcode = 6'b110000;
        step("ill_dec", 4'd2, c_dec, 2'b00);
        for (int i = 0; i < 10; i++) begin
            step("ill_halt", 4'd11, 21'd0, 2'b11);
        end
        #2;
        reset = 1'b1;
        #1;
        look("ill_rst", 4'd0, 21'd0, 2'b00);
        @(negedge clock);
        reset = 1'b0;
        step("halt_fetch", 4'd1, c_fetch, 2'b00);

        // Legal HALT opcode: halted without illegal
        opcode = 6'b111111;
        step("halt_dec", 4'd2, c_dec, 2'b00);
        step("halt_st", 4'd11, 21'd0, 2'b10);
        step("halt_stay", 4'd11, 21'd0, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
